// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: sequencer state encoding and response flag bundle
`include "defines.sv"
package alu_seq_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} alu_seq_state_t;
  typedef struct packed {
    logic zero;
    logic div0;
  } alu_seq_flags_t;
endpackage

// File: rtl/alu.sv
// alu: combinational B-op-A unit; unknown opcodes pass B through
module alu #(
  parameter int DATA_W = `DATA_BITS
) (
  input  logic [DATA_W-1:0] data_A,
  input  logic [DATA_W-1:0] data_B,
  input  logic [DATA_W-1:0] op_code,
  output logic [DATA_W-1:0] result
);
  always_comb begin
    result = data_B;
    case (op_code)
      DATA_W'(`SUM):  result = data_B + data_A;
      DATA_W'(`SUB):  result = data_B - data_A;
      DATA_W'(`MULT): result = data_B * data_A;
      DATA_W'(`DIV):  result = data_A == '0 ? '1 : data_B / data_A;
      DATA_W'(`INC):  result = data_B + DATA_W'(1);
      DATA_W'(`DEC):  result = data_B - DATA_W'(1);
      DATA_W'(`AND):  result = data_B & data_A;
      DATA_W'(`OR):   result = data_B | data_A;
      DATA_W'(`XOR):  result = data_B ^ data_A;
      default:        result = data_B;
    endcase
  end
endmodule

// File: rtl/defines.sv
// defines: shared ALU opcode encodings and default data width
`ifndef DEFINES_SV
`define DEFINES_SV
`define DATA_BITS 8
`define SUM  0
`define SUB  1
`define MULT 2
`define DIV  3
`define INC  4
`define DEC  5
`define AND  6
`define OR   7
`define XOR  8
`endif

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one request to the ALU, captures its result and returns it with flags
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = `DATA_BITS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic              req_use_acc,
  output logic [DATA_W-1:0] alu_data_A,
  output logic [DATA_W-1:0] alu_data_B,
  output logic [DATA_W-1:0] alu_op_code,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_div0,
  output logic [DATA_W-1:0] acc_out
);
  alu_seq_state_t state, state_d;
  alu_seq_flags_t flags;
  logic [DATA_W-1:0] acc, cap;
  logic accept, div0;
  always_comb begin
    req_ready = state == IDLE;
    rsp_valid = state == DONE;
    accept = req_ready && req_valid;
    div0 = alu_op_code == DATA_W'(`DIV) && alu_data_A == '0;
    cap = div0 ? '1 : alu_result;
    state_d = accept ? ISSUE :
              state == ISSUE ? DONE :
              state == DONE && rsp_ready ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      alu_data_A <= '0;
      alu_data_B <= '0;
      alu_op_code <= '0;
      acc <= '0;
      flags <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        alu_op_code <= req_op;
        alu_data_A <= req_a;
        alu_data_B <= req_use_acc ? acc : req_b;
      end
      if (state == ISSUE) begin
        acc <= cap;
        flags <= '{zero: cap == '0, div0: div0};
      end
    end
  end
  // the accumulator doubles as the response payload register
  assign rsp_result = acc;
  assign acc_out = acc;
  assign rsp_zero = flags.zero;
  assign rsp_div0 = flags.div0;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed and random checks of the sequencer driving an ALU
module tb_alu_op_sequencer;
  logic clk = 0, reset = 1;
  logic req_valid = 0, req_ready, req_use_acc = 0, rsp_valid, rsp_ready = 0, rsp_zero, rsp_div0;
  logic [7:0] req_op = 0, req_a = 0, req_b = 0;
  logic [7:0] alu_data_A, alu_data_B, alu_op_code, alu_result, rsp_result, acc_out;
  int checks = 0, errors = 0;
  int acc_m = 0;
  int r;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DATA_W(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_use_acc(req_use_acc),
    .alu_data_A(alu_data_A), .alu_data_B(alu_data_B), .alu_op_code(alu_op_code),
    .alu_result(alu_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_div0(rsp_div0), .acc_out(acc_out)
  );

  alu #(.DATA_W(8)) u_alu (
    .data_A(alu_data_A), .data_B(alu_data_B), .op_code(alu_op_code), .result(alu_result)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model(input int op, input int a, input int b);
    case (op)
      `SUM:  return (b + a) & 255;
      `SUB:  return (b - a) & 255;
      `MULT: return (b * a) & 255;
      `DIV:  return a == 0 ? 255 : b / a;
      `INC:  return (b + 1) & 255;
      `DEC:  return (b - 1) & 255;
      `AND:  return b & a;
      `OR:   return b | a;
      `XOR:  return b ^ a;
      default: return b;
    endcase
  endfunction

  // issue one op, optionally stall the response for `hold` cycles while a rival request waits
  task automatic do_op(input int op, input int a, input int b, input bit ua, input int hold, output int res);
    int bv, er, n;
    bit ed;
    bv = ua ? acc_m : b;
    er = model(op, a, bv);
    ed = op == `DIV && a == 0;
    @(negedge clk);
    req_valid = 1; req_op = 8'(op); req_a = 8'(a); req_b = 8'(b); req_use_acc = ua;
    check("ready_idle", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 0;
    check("issue_no_rsp", rsp_valid, 0);
    check("alu_B", alu_data_B, bv);
    check("alu_op", alu_op_code, op);
    n = 0;
    while (!rsp_valid && n < 8) begin
      @(posedge clk); #1; n++;
    end
    check("rsp_valid", rsp_valid, 1);
    check("result", rsp_result, er);
    check("zero", rsp_zero, er == 0);
    check("div0", rsp_div0, ed);
    check("acc", acc_out, er);
    check("busy", req_ready, 0);
    acc_m = er;
    res = rsp_result;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1; req_a = 8'(~a); req_b = 8'(~b); req_op = `SUM;
      @(posedge clk); #1;
      check("hold_valid", rsp_valid, 1);
      check("hold_result", rsp_result, er);
      check("hold_ready", req_ready, 0);
      check("hold_aluA", alu_data_A, a);
    end
    req_valid = 0;
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    check("rsp_drop", rsp_valid, 0);
    check("back_idle", req_ready, 1);
    check("acc_kept", acc_out, er);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", req_ready, 1);
    check("rst_valid", rsp_valid, 0);
    check("rst_aluA", alu_data_A, 0);
    check("rst_aluB", alu_data_B, 0);
    check("rst_op", alu_op_code, 0);
    check("rst_res", {rsp_result, rsp_zero, rsp_div0}, 0);
    check("rst_acc", acc_out, 0);
    @(negedge clk) reset = 0;
    do_op(`SUM, 3, 5, 0, 0, r);  check("t1", r, 8);
    do_op(`SUB, 5, 5, 0, 0, r);  check("t2a", r, 0);
    do_op(`SUB, 1, 0, 0, 0, r);  check("t2b", r, 255);
    do_op(`DIV, 0, 9, 0, 0, r);  check("t3a", r, 255);
    do_op(`DIV, 3, 9, 0, 0, r);  check("t3b", r, 3);
    do_op(`SUM, 2, 10, 0, 0, r); check("t4a", r, 12);
    do_op(`INC, 0, 99, 1, 0, r); check("t4b", r, 13);
    do_op(`MULT, 20, 0, 1, 0, r); check("t4c", r, 4);
    do_op(`XOR, 15, 51, 0, 5, r); check("t5", r, 60);
    do_op(9, 7, 77, 0, 0, r);    check("unknown_op", r, 77);
    // reset while the op sits in ISSUE
    @(negedge clk);
    req_valid = 1; req_op = `SUM; req_a = 1; req_b = 1; req_use_acc = 0;
    @(posedge clk); #1;
    req_valid = 0; reset = 1;
    @(posedge clk); #1;
    reset = 0;
    acc_m = 0;
    check("t6_valid", rsp_valid, 0);
    check("t6_ready", req_ready, 1);
    check("t6_acc", acc_out, 0);
    check("t6_aluA", alu_data_A, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("t6_no_rsp", rsp_valid, 0);
    end
    for (int i = 0; i < 40; i++)
      do_op($urandom_range(0, 9), $urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 255),
            $urandom_range(0, 255), $urandom_range(0, 1) == 1, 0, r);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
